parity_merger: RTL
==================

Name: parity_merger

Overview:
- Counterpart to the odd/even splitter: reads back an even-value bank and an odd-value bank and re-interleaves them into a single write stream to a destination RAM.
- Output order alternates even, odd, even, odd, … starting with the even bank. Once one bank is exhausted, the rest of the other bank is copied in order.
- Both banks have the same synchronous-read interface as the team ROM: the address is registered on a clock edge and the data is valid on the next cycle.

Parameters:
- DATA_W, 8, word width of the banks and the destination memory.
- BANK_DEPTH, 4, maximum number of entries per bank.
- IDX_W, 2, bank index width; must equal clog2(BANK_DEPTH).
- CNT_W, 3, count width; must equal clog2(BANK_DEPTH+1).
- ADDR_W, 4, destination address width; 2^ADDR_W must be at least 2*BANK_DEPTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin a merge; honoured only in IDLE.
- even_count  in  CNT_W  number of valid even-bank entries; sampled on the start edge.
- odd_count  in  CNT_W  number of valid odd-bank entries; sampled on the start edge.
- even_addr  out  IDX_W  even-bank read index.
- even_data  in  DATA_W  even-bank read data, valid 1 cycle after even_addr.
- odd_addr  out  IDX_W  odd-bank read index.
- odd_data  in  DATA_W  odd-bank read data, valid 1 cycle after odd_addr.
- mem_we  out  1  destination write strobe.
- mem_addr  out  ADDR_W  destination write address.
- mem_data  out  DATA_W  destination write data.
- busy  out  1  high from the cycle after an accepted start through the DONE cycle.
- done  out  1  single-cycle pulse after the last write.

Behaviour:
- Reset (async, rst=1): state=IDLE. All outputs are 0: even_addr, odd_addr, mem_we, mem_addr, mem_data, busy, done. The internal rd_even, rd_odd and wr_ptr counters are also cleared to 0. Asserting rst mid-merge aborts immediately: no further writes and no done pulse.
- Counts are latched on the accepted start edge. A count greater than BANK_DEPTH is clamped to BANK_DEPTH.
- A start asserted while not in IDLE is ignored. No queueing.
- State IDLE: on start, latch the counts, clear rd_even, rd_odd and wr_ptr, set the pick flag to EVEN.
  - If both counts are 0, go to DONE.
  - Otherwise go to FETCH.
- State FETCH (1 cycle): choose the source bank.
  - Choose EVEN if pick=EVEN and rd_even<even_count, or if the odd bank is exhausted.
  - Otherwise choose ODD.
  - Drive the chosen bank's addr with its rd counter value. Go to WRITE.
- State WRITE (1 cycle): mem_we=1, mem_addr=wr_ptr, mem_data=the chosen bank's data (the registered ROM-style output).
  - Increment the chosen rd counter and wr_ptr.
  - Set pick to the opposite of the source just used.
  - If rd_even+rd_odd after the increment equals even_count+odd_count, go to DONE; otherwise go to FETCH.
- State DONE (1 cycle): done=1, busy=1. Go to IDLE.
- Throughput: one word per 2 cycles. For N=even_count+odd_count≥1:
  - the first mem_we comes 2 cycles after the start edge;
  - the last mem_we comes 2N cycles after the start edge;
  - done comes 2N+1 cycles after the start edge.
- mem_we is high only in WRITE. mem_addr and mem_data hold their last value in all other states.
- wr_ptr runs 0..N-1 and never wraps. The ADDR_W constraint guarantees this.
- The bank addr of the source not chosen holds its previous value. Both bank addrs are 0 after reset.
- start and rst asserted in the same cycle: rst wins.

Test Plan:
- Balanced merge: even bank {4,2,10,0}, odd bank {5,1,3,7}, counts 4/4, pulse start. Required response: writes at addr 0..7 with data 4,5,2,1,10,3,0,7; mem_we high every other cycle; done pulses 17 cycles after start.
- Unbalanced merge: even {4,2,10,12}, odd {5}, counts 4/1. Required response: writes 4,5,2,10,12 at addr 0..4; done pulses 11 cycles after start.
- Empty bank: counts 0/3 with odd bank {9,7,3}. Required response: writes 9,7,3 at addr 0..2. Then counts 0/0: required response is done exactly 1 cycle after start, mem_we never asserted.
- Clamp and ignore: counts 7/0. Required response: exactly 4 writes (even bank entries 0..3). A second start pulsed mid-merge produces no extra writes and no second done.
- Reset mid-operation: assert rst after the 3rd write of the balanced case. Required response: all outputs go to 0 immediately and asynchronously, with no done. A subsequent start then reproduces the full balanced sequence from addr 0.

Source files
------------

// File: rtl/parity_merger.sv
// parity_merger: re-interleaves an even-value bank and an odd-value bank into
//   one destination write stream (even, odd, even, ... then the remainder).
// Ports: start/even_count/odd_count request a merge; even_addr/even_data and
//   odd_addr/odd_data read the two synchronous-read banks; mem_we/mem_addr/
//   mem_data write the destination; busy spans the merge, done pulses at end.
// Latency: first write 2 cycles after start, one word per 2 cycles, done at 2N+1.
module parity_merger #(
  parameter int DATA_W     = 8,
  parameter int BANK_DEPTH = 4,
  parameter int IDX_W      = 2,
  parameter int CNT_W      = 3,
  parameter int ADDR_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  even_count,
  input  logic [CNT_W-1:0]  odd_count,
  output logic [IDX_W-1:0]  even_addr,
  input  logic [DATA_W-1:0] even_data,
  output logic [IDX_W-1:0]  odd_addr,
  input  logic [DATA_W-1:0] odd_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    ec_q, ec_d, oc_q, oc_d;
  logic [CNT_W-1:0]    rd_even_q, rd_even_d, rd_odd_q, rd_odd_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic                pick_q, pick_d;   // 1 = odd bank preferred next
  logic                src_q, src_d;     // 1 = current word comes from odd bank
  logic [IDX_W-1:0]    even_addr_q, even_addr_d, odd_addr_q, odd_addr_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_data_q, mem_data_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic                sel_odd;

  function automatic logic [CNT_W-1:0] clamp(input logic [CNT_W-1:0] c);
    return (c > CNT_W'(BANK_DEPTH)) ? CNT_W'(BANK_DEPTH) : c;
  endfunction

  // Even wins when it is its turn and it still has entries, or when the odd
  // bank has nothing left; otherwise odd.
  function automatic logic choose_odd(input logic             pick_odd,
                                      input logic [CNT_W-1:0] re,
                                      input logic [CNT_W-1:0] ro,
                                      input logic [CNT_W-1:0] ec,
                                      input logic [CNT_W-1:0] oc);
    return !((!pick_odd && (re < ec)) || (ro >= oc));
  endfunction

  // The bank read data only exists during WRITE (the bank registers the
  // address at the end of FETCH), so it is forwarded directly then and the
  // captured copy holds the bus afterwards.
  assign mem_data  = (state_q == WRITE) ? (src_q ? odd_data : even_data) : mem_data_q;
  assign even_addr = even_addr_q;
  assign odd_addr  = odd_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign busy      = busy_q;
  assign done      = done_q;

  always_comb begin
    state_d     = state_q;
    ec_d        = ec_q;
    oc_d        = oc_q;
    rd_even_d   = rd_even_q;
    rd_odd_d    = rd_odd_q;
    wr_ptr_d    = wr_ptr_q;
    pick_d      = pick_q;
    src_d       = src_q;
    even_addr_d = even_addr_q;
    odd_addr_d  = odd_addr_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    sel_odd     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          ec_d      = clamp(even_count);
          oc_d      = clamp(odd_count);
          rd_even_d = '0;
          rd_odd_d  = '0;
          wr_ptr_d  = '0;
          pick_d    = 1'b0;
          busy_d    = 1'b1;
          if ((ec_d == '0) && (oc_d == '0)) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            // Source and bank address are settled on entry to FETCH so the
            // bank sees the address for the whole FETCH cycle.
            state_d = FETCH;
            sel_odd = choose_odd(1'b0, '0, '0, ec_d, oc_d);
            src_d   = sel_odd;
            if (sel_odd) odd_addr_d  = '0;
            else         even_addr_d = '0;
          end
        end
      end

      FETCH: begin
        state_d    = WRITE;
        mem_we_d   = 1'b1;
        mem_addr_d = wr_ptr_q;
      end

      WRITE: begin
        mem_data_d = src_q ? odd_data : even_data;
        if (src_q) rd_odd_d  = rd_odd_q + 1'b1;
        else       rd_even_d = rd_even_q + 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
        pick_d   = !src_q;
        if (({1'b0, rd_even_d} + {1'b0, rd_odd_d}) == ({1'b0, ec_q} + {1'b0, oc_q})) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d = FETCH;
          sel_odd = choose_odd(pick_d, rd_even_d, rd_odd_d, ec_q, oc_q);
          src_d   = sel_odd;
          if (sel_odd) odd_addr_d  = rd_odd_d[IDX_W-1:0];
          else         even_addr_d = rd_even_d[IDX_W-1:0];
        end
      end

      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ec_q        <= '0;
      oc_q        <= '0;
      rd_even_q   <= '0;
      rd_odd_q    <= '0;
      wr_ptr_q    <= '0;
      pick_q      <= 1'b0;
      src_q       <= 1'b0;
      even_addr_q <= '0;
      odd_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ec_q        <= ec_d;
      oc_q        <= oc_d;
      rd_even_q   <= rd_even_d;
      rd_odd_q    <= rd_odd_d;
      wr_ptr_q    <= wr_ptr_d;
      pick_q      <= pick_d;
      src_q       <= src_d;
      even_addr_q <= even_addr_d;
      odd_addr_q  <= odd_addr_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

endmodule
